// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Resolves memory freezes, branch redirects, multi-cycle mul/div waits and
// load-use hazards. It also keeps a saturating stall-cycle counter and a
// sticky mul/div timeout flag.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_md_start_i,
  input  logic             md_done_i,
  input  logic             dmem_busy_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_hold_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic             md_timeout_o
);

  // The wait counter only has to reach MD_TIMEOUT-1.
  localparam int WC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              timeout_q, timeout_d;
  logic              load_use;

  // Load in EX feeding a register that decode reads; x0 never creates a hazard.
  assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

  // Next-state logic and combinational pipeline controls.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    timeout_d     = timeout_q;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    ex_hold_o     = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      state_d       = RUN;
      wcnt_d        = '0;
    end else begin
      case (state_q)
        RUN: begin
          wcnt_d = '0;
          if (dmem_busy_i) begin
            // Freeze everything; a taken branch stays in EX and redirects later.
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
          end else if (ex_branch_taken_i) begin
            // Wrong-path instructions are squashed, so any load-use is moot.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (ex_md_start_i && !md_done_i) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            ex_hold_o     = 1'b1;
            state_d       = MD_WAIT;
          end else if (load_use) begin
            // One bubble is enough; forwarding supplies the loaded value.
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          ex_hold_o     = 1'b1;
          if (md_done_i) begin
            // Let the result leave EX on the done cycle.
            ex_hold_o = 1'b0;
            state_d   = RUN;
            wcnt_d    = '0;
          end else if (wcnt_q == WC_LAST) begin
            timeout_d = 1'b1;
            state_d   = RUN;
            wcnt_d    = '0;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
      if (!pc_write_o && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count_o = stall_cnt_q;
  assign md_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Two instances share the stimulus:
// dut_a uses the default parameters, and dut_b (CNT_W=4, MD_TIMEOUT=8)
// covers the timeout and counter-saturation cases.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       use1 = 0, use2 = 0, mrd = 0, br = 0, mds = 0, mdd = 0, busy = 0;

  logic        a_pcw, a_ifw, a_iff, a_ief, a_hold, a_to;
  logic [31:0] a_cnt;
  logic        b_pcw, b_ifw, b_iff, b_ief, b_hold, b_to;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int hold_n, stall_n;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_uses_rs1_i(use1), .id_uses_rs2_i(use2), .ex_rd_i(rd),
    .ex_mem_read_i(mrd), .ex_branch_taken_i(br), .ex_md_start_i(mds),
    .md_done_i(mdd), .dmem_busy_i(busy), .pc_write_o(a_pcw),
    .if_id_write_o(a_ifw), .if_id_flush_o(a_iff), .id_ex_flush_o(a_ief),
    .ex_hold_o(a_hold), .stall_count_o(a_cnt), .md_timeout_o(a_to)
  );

  pipeline_hazard_ctrl #(.CNT_W(4), .MD_TIMEOUT(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_uses_rs1_i(use1), .id_uses_rs2_i(use2), .ex_rd_i(rd),
    .ex_mem_read_i(mrd), .ex_branch_taken_i(br), .ex_md_start_i(mds),
    .md_done_i(mdd), .dmem_busy_i(busy), .pc_write_o(b_pcw),
    .if_id_write_o(b_ifw), .if_id_flush_o(b_iff), .id_ex_flush_o(b_ief),
    .ex_hold_o(b_hold), .stall_count_o(b_cnt), .md_timeout_o(b_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed at posedge+1.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs1 = '0; rs2 = '0; rd = '0;
    use1 = 0; use2 = 0; mrd = 0; br = 0; mds = 0; mdd = 0; busy = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    clear_in();
    cyc();
    chk("rst_pcw",  32'(a_pcw), 0);
    chk("rst_ifw",  32'(a_ifw), 0);
    chk("rst_iff",  32'(a_iff), 1);
    chk("rst_ief",  32'(a_ief), 1);
    chk("rst_hold", 32'(a_hold), 0);
    chk("rst_cnt",  a_cnt, 0);
    chk("rst_to",   32'(a_to), 0);
    rst = 1'b0;
    #1;
    chk("run_pcw", 32'(a_pcw), 1);

    // 1: load-use on rs2
    mrd = 1; rd = 5'd5; rs2 = 5'd5; use2 = 1;
    #1;
    chk("lu_pcw", 32'(a_pcw), 0);
    chk("lu_ifw", 32'(a_ifw), 0);
    chk("lu_ief", 32'(a_ief), 1);
    chk("lu_iff", 32'(a_iff), 0);
    cyc();
    clear_in();
    #1;
    chk("lu_cnt", a_cnt, 1);
    chk("lu_after_pcw", 32'(a_pcw), 1);

    // 2: branch overrides load-use; x0 never stalls
    mrd = 1; rd = 5'd5; rs2 = 5'd5; use2 = 1; br = 1;
    #1;
    chk("br_pcw", 32'(a_pcw), 1);
    chk("br_iff", 32'(a_iff), 1);
    chk("br_ief", 32'(a_ief), 1);
    cyc();
    clear_in();
    mrd = 1; rd = 5'd0; rs1 = 5'd0; use1 = 1;
    #1;
    chk("br_cnt", a_cnt, 1);
    chk("x0_pcw", 32'(a_pcw), 1);
    chk("x0_ief", 32'(a_ief), 0);
    cyc();
    chk("x0_cnt", a_cnt, 1);

    // 3: mul/div with done on the 10th wait cycle
    do_reset();
    hold_n = 0;
    mds = 1;
    #1;
    chk("md_start_pcw", 32'(a_pcw), 0);
    hold_n += int'(a_hold);
    cyc();
    mds = 0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      hold_n += int'(a_hold);
      cyc();
    end
    mdd = 1;
    #1;
    chk("md_done_hold", 32'(a_hold), 0);
    chk("md_done_pcw",  32'(a_pcw), 0);
    cyc();
    mdd = 0;
    #1;
    chk("md_hold_n", 32'(hold_n), 10);
    chk("md_cnt",    a_cnt, 11);
    chk("md_run_pcw", 32'(a_pcw), 1);
    mds = 1; mdd = 1;
    #1;
    chk("md_same_pcw",  32'(a_pcw), 1);
    chk("md_same_hold", 32'(a_hold), 0);
    cyc();
    clear_in();
    #1;
    chk("md_same_cnt", a_cnt, 11);
    chk("md_same_run", 32'(a_pcw), 1);

    // 4: timeout on dut_b (MD_TIMEOUT=8)
    do_reset();
    mds = 1;
    #1;
    stall_n = int'(!b_pcw);
    cyc();
    mds = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (b_pcw) break;
      chk("to_early", 32'(b_to), 0);
      stall_n++;
      cyc();
    end
    chk("to_stalls", 32'(stall_n), 9);
    chk("to_flag",   32'(b_to), 1);
    chk("to_cnt",    32'(b_cnt), 9);
    chk("to_run",    32'(b_pcw), 1);
    cyc(); cyc(); cyc();
    chk("to_sticky", 32'(b_to), 1);

    // 5: memory freeze defers a taken branch
    do_reset();
    busy = 1; br = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fz_hold", 32'(a_hold), 1);
      chk("fz_iff",  32'(a_iff), 0);
      chk("fz_ief",  32'(a_ief), 0);
      chk("fz_pcw",  32'(a_pcw), 0);
      cyc();
    end
    busy = 0;
    #1;
    chk("fz_br_iff",  32'(a_iff), 1);
    chk("fz_br_ief",  32'(a_ief), 1);
    chk("fz_br_pcw",  32'(a_pcw), 1);
    chk("fz_br_hold", 32'(a_hold), 0);
    cyc();
    clear_in();
    #1;
    chk("fz_cnt", a_cnt, 3);

    // 6: asynchronous reset in the middle of MD_WAIT, then saturation
    do_reset();
    mds = 1;
    cyc();
    mds = 0;
    cyc(); cyc(); cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pcw",  32'(b_pcw), 0);
    chk("ar_iff",  32'(b_iff), 1);
    chk("ar_ief",  32'(b_ief), 1);
    chk("ar_hold", 32'(b_hold), 0);
    chk("ar_cnt",  32'(b_cnt), 0);
    chk("ar_to",   32'(b_to), 0);
    chk("ar_a_cnt", a_cnt, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("ar_run_pcw",  32'(b_pcw), 1);
    chk("ar_run_hold", 32'(b_hold), 0);
    busy = 1;
    for (int i = 0; i < 20; i++) cyc();
    busy = 0;
    #1;
    chk("sat_b_cnt", 32'(b_cnt), 15);
    chk("sat_a_cnt", a_cnt, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
